// File: rtl/seg7_scan_if.sv
// Bus bundle between a multiplexed 7-segment display and the scan reader.
//   seg_n       : segment lines, active low, bit0=a .. bit6=g
//   an_n        : digit enables, active low, bit i = digit i
//   bcd_value   : last complete frame, nibble i = digit i
//   digit_err   : per-digit invalid-pattern flags of the last frame
//   frame_valid : one-clock pulse when bcd_value/digit_err update
//   stale       : no frame completed within the timeout window
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] bcd_value;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;
  logic                stale;

  // Display side (or stimulus) drives the bus and observes the results.
  modport master (
    output seg_n,
    output an_n,
    input  bcd_value,
    input  digit_err,
    input  frame_valid,
    input  stale
  );

  // Reader side.
  modport slave (
    input  seg_n,
    input  an_n,
    output bcd_value,
    output digit_err,
    output frame_valid,
    output stale
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers packed BCD digits from a multiplexed, active-low 7-segment bus.
// The bus is synchronized, filtered for stability, and each stable digit
// period is decoded once into a shadow frame; a full set of digits is
// published as one frame. A watchdog flags scanning that has stalled.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : seg7_scan_if slave (seg_n/an_n in; bcd_value, digit_err,
//         frame_valid, stale out)
module seg7_scan_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned TIMEOUT       = 65536
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);
  localparam int unsigned SW = DIGITS + 7;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {StSettle, StHold} state_e;

  // Returns {err, nibble}; anything outside the ten digit glyphs is an error.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h18:   res = 5'h09;
      default: res = 5'h1F;
    endcase
    return res;
  endfunction

  logic [SW-1:0]       r_sync1, r_sync2, r_prev;
  state_e              r_state;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_shadow, r_bcd;
  logic [DIGITS-1:0]   r_shadow_err, r_mask, r_err;
  logic                r_fv, r_stale;
  logic [TW-1:0]       r_tcnt;

  logic [DIGITS-1:0]   w_sel;
  logic                w_same, w_onehot, w_eval, w_capture, w_full, w_timeout;
  logic [4:0]          w_dec;

  always_comb begin
    w_same    = (r_sync2 == r_prev);
    w_sel     = ~r_sync2[SW-1:7];
    w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
    // The current sample is the STABLE_CYCLES-th identical one in a row.
    w_eval    = (r_state == StSettle) && w_same && (r_cnt >= CW'(STABLE_CYCLES - 1));
    w_capture = w_eval && w_onehot;
    w_dec     = decode(r_sync2[6:0]);
    w_full    = &r_mask;
    w_timeout = (r_tcnt == TW'(TIMEOUT - 1));
  end

  // Input synchronizer; idle bus is all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= {bus.an_n, bus.seg_n};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Stability filter: one evaluation per stable period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StSettle;
      r_cnt   <= '0;
    end else if (!w_same) begin
      r_state <= StSettle;
      r_cnt   <= CW'(1);
    end else if (w_eval) begin
      r_state <= StHold;
      r_cnt   <= CW'(STABLE_CYCLES);
    end else if (r_state == StSettle) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Shadow frame assembly, frame publish and stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_mask       <= '0;
      r_bcd        <= '0;
      r_err        <= '0;
      r_fv         <= 1'b0;
      r_stale      <= 1'b0;
      r_tcnt       <= '0;
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_capture && w_sel[i]) begin
          r_shadow[4*i +: 4] <= w_dec[3:0];
          r_shadow_err[i]    <= w_dec[4];
        end
      end
      r_mask <= ((w_full || w_timeout) ? '0 : r_mask) | (w_capture ? w_sel : '0);
      r_fv   <= w_full;
      if (w_full) begin
        r_bcd <= r_shadow;
        r_err <= r_shadow_err;
      end
      // A completing frame takes priority over an expiring watchdog.
      if (w_full) begin
        r_tcnt  <= '0;
        r_stale <= 1'b0;
      end else if (w_timeout) begin
        r_tcnt  <= '0;
        r_stale <= 1'b1;
      end else begin
        r_tcnt  <= r_tcnt + 1'b1;
      end
    end
  end

  assign bus.bcd_value   = r_bcd;
  assign bus.digit_err   = r_err;
  assign bus.frame_valid = r_fv;
  assign bus.stale       = r_stale;
endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_reader #(
    .DIGITS(DIGITS),
    .STABLE_CYCLES(8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame monitor: counts pulses and latches what was published.
  int          fv_total   = 0;
  logic [15:0] last_bcd   = '0;
  logic [3:0]  last_err   = '0;
  logic        last_stale = 1'b0;
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_total   = fv_total + 1;
      last_bcd   = bus.bcd_value;
      last_err   = bus.digit_err;
      last_stale = bus.stale;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [6:0] seg, input int n);
    logic [3:0] an;
    an = 4'hF;
    an[idx] = 1'b0;
    bus.an_n  = an;
    bus.seg_n = seg;
    step(n);
  endtask

  task automatic idle(input int n);
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    step(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  int base;

  initial begin
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    step(3);
    @(negedge clk);
    check_eq("rst_bcd", 32'(bus.bcd_value), 32'h0);
    check_eq("rst_err", 32'(bus.digit_err), 32'h0);
    check_eq("rst_fv", 32'(bus.frame_valid), 32'h0);
    check_eq("rst_stale", 32'(bus.stale), 32'h0);
    rst = 1'b0;
    step(2);

    // Basic scan 1,2,3,4.
    base = fv_total;
    drive(0, 7'h79, 20);
    drive(1, 7'h24, 20);
    drive(2, 7'h30, 20);
    drive(3, 7'h19, 20);
    idle(5);
    check_eq("s1_frames", 32'(fv_total - base), 32'd1);
    check_eq("s1_bcd", 32'(last_bcd), 32'h4321);
    check_eq("s1_err", 32'(last_err), 32'h0);

    // Unstable digit 1 never captures.
    do_reset();
    base = fv_total;
    drive(0, 7'h79, 20);
    for (int k = 0; k < 6; k++) drive(1, (k % 2 == 1) ? 7'h00 : 7'h40, 4);
    drive(2, 7'h30, 20);
    drive(3, 7'h19, 20);
    idle(5);
    check_eq("s2_noframe", 32'(fv_total - base), 32'd0);
    drive(1, 7'h40, 20);
    idle(5);
    check_eq("s2_frames", 32'(fv_total - base), 32'd1);
    check_eq("s2_bcd", 32'(last_bcd), 32'h4301);

    // Blank digit 2 flags an error.
    do_reset();
    drive(0, 7'h12, 20);
    drive(1, 7'h12, 20);
    drive(2, 7'h7F, 20);
    drive(3, 7'h12, 20);
    idle(5);
    check_eq("s3_bcd", 32'(last_bcd), 32'h5F55);
    check_eq("s3_err", 32'(last_err), 32'h4);

    // Multi-low enables and blanking, then watchdog, then recovery.
    do_reset();
    base = fv_total;
    bus.an_n  = 4'b1100;
    bus.seg_n = 7'h40;
    step(50);
    check_eq("s4_stale_early", 32'(bus.stale), 32'h0);
    idle(TIMEOUT);
    check_eq("s4_stale", 32'(bus.stale), 32'h1);
    check_eq("s4_noframe", 32'(fv_total - base), 32'd0);
    drive(0, 7'h18, 20);
    drive(1, 7'h18, 20);
    drive(2, 7'h18, 20);
    drive(3, 7'h18, 20);
    idle(5);
    check_eq("s4_frames", 32'(fv_total - base), 32'd1);
    check_eq("s4_bcd", 32'(last_bcd), 32'h9999);
    check_eq("s4_stale_at_fv", 32'(last_stale), 32'h0);
    check_eq("s4_stale_after", 32'(bus.stale), 32'h0);

    // Reset mid-frame discards partial captures.
    drive(0, 7'h79, 20);
    drive(1, 7'h24, 20);
    rst = 1'b1;
    step(3);
    @(negedge clk);
    check_eq("s5_rst_bcd", 32'(bus.bcd_value), 32'h0);
    check_eq("s5_rst_err", 32'(bus.digit_err), 32'h0);
    check_eq("s5_rst_fv", 32'(bus.frame_valid), 32'h0);
    check_eq("s5_rst_stale", 32'(bus.stale), 32'h0);
    rst = 1'b0;
    base = fv_total;
    drive(2, 7'h02, 20);
    drive(3, 7'h78, 20);
    idle(5);
    check_eq("s5_partial", 32'(fv_total - base), 32'd0);
    drive(0, 7'h00, 20);
    drive(1, 7'h40, 20);
    idle(5);
    check_eq("s5_frames", 32'(fv_total - base), 32'd1);
    check_eq("s5_bcd", 32'(last_bcd), 32'h7608);

    // Revisited digit keeps the latest value.
    do_reset();
    base = fv_total;
    drive(0, 7'h79, 20);
    drive(0, 7'h24, 20);
    drive(1, 7'h79, 20);
    drive(2, 7'h30, 20);
    drive(3, 7'h19, 20);
    idle(5);
    check_eq("s6_frames", 32'(fv_total - base), 32'd1);
    check_eq("s6_bcd", 32'(last_bcd), 32'h4312);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
